pong_ai_paddle: RTL and testbench
=================================

PONG_AI_PADDLE -- requirements
Module: pong_ai_paddle

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SIDE  0  0 = left paddle (ball approaches when ball_x decreases); 1 = right paddle (ball approaches when ball_x increases)
  PADDLE_H  4  paddle height in rows; the paddle covers paddle_y..paddle_y+PADDLE_H-1
  FIELD_MAX  127  largest legal row index
  HOME_Y  62  paddle_y target while the ball recedes
  REACT_DELAY  2  cycles spent in WAIT after each direction change; 0 = no WAIT
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  controller active
  ball_x  in  7  ball column from the game core
  ball_y  in  7  ball row from the game core
  paddle_y  in  7  top row of the controlled paddle
  up  out  1  registered request to move the paddle up (toward row 0)
  down  out  1  registered request to move the paddle down
  state  out  3  current FSM state encoding

Function
REQ-003 FSM states and encodings SHALL be IDLE=0, SAMPLE=1, WAIT=2, TRACK=3, RETURN=4; values 5-7 SHALL go to IDLE.
REQ-004 In any state, enable=0 SHALL force IDLE on the next edge; this takes priority over all other transitions.
REQ-005 IDLE with enable=1: the block SHALL capture prev_x<=ball_x and go to SAMPLE.
REQ-006 SAMPLE: while ball_x==prev_x, the FSM SHALL stay in SAMPLE.
REQ-007 SAMPLE: when ball_x!=prev_x, the block SHALL set dir (1 = approaching, per SIDE) and update prev_x.
  - It SHALL then go to WAIT with the counter loaded to REACT_DELAY-1.
  - If REACT_DELAY=0, it SHALL go directly to TRACK (dir=1) or RETURN (dir=0).
REQ-008 WAIT SHALL decrement the counter each cycle; at counter 0 it SHALL go to TRACK if dir=1, else RETURN.
REQ-009 WAIT, TRACK, RETURN: prev_x<=ball_x every cycle. A movement opposite to dir SHALL:
  - flip dir;
  - reload the counter;
  - enter or re-enter WAIT, with the REACT_DELAY=0 bypass applied as in REQ-007.
  An unchanged ball_x SHALL keep dir.
REQ-010 up and down SHALL be registered; on each edge their next values SHALL be computed from the current state and the current inputs.
REQ-011 TRACK rule:
  - up<=1 iff ball_y<paddle_y;
  - down<=1 iff ball_y>paddle_y+PADDLE_H-1;
  - otherwise both 0.
REQ-012 RETURN rule: up<=1 iff paddle_y>HOME_Y; down<=1 iff paddle_y<HOME_Y; both 0 when equal.
REQ-013 In IDLE, SAMPLE and WAIT, up and down SHALL be 0 on the next edge.
REQ-014 Comparisons SHALL use 8-bit unsigned arithmetic so that paddle_y+PADDLE_H-1 never wraps.
REQ-015 Limits: up SHALL never assert when paddle_y==0; down SHALL never assert when paddle_y>=FIELD_MAX-PADDLE_H+1.
REQ-016 up and down SHALL never be 1 in the same cycle.

Reset
REQ-017 reset=0 SHALL immediately, without waiting for a clock edge, set:
  - state=IDLE;
  - up=0, down=0;
  - prev_x=0, dir=0, counter=0.
REQ-018 Reset asserted mid-operation SHALL abandon the operation; after release the FSM SHALL restart from IDLE and require a fresh SAMPLE.

Verification
REQ-019 Directed scenarios; SIDE=0 and default parameters unless stated.
  - Reset: reset=0 at an arbitrary time, including mid-TRACK -> up=0, down=0, state=0 before the next edge.
  - Approach: enable=1, ball_x 100 then 99, ball_y=10, paddle_y=50 -> state 0,1,2,2,3; up=1 from the edge after state first reads 3; down=0.
  - Window: TRACK, ball_y=52, paddle_y=50 -> up=0, down=0; ball_y=54 -> down=1 next cycle.
  - Recede: ball_x 40 then 41, paddle_y=20, paddle stepping +1 per cycle while down=1 -> state reaches 4; down=1 until paddle_y=62, then up=0, down=0.
  - Bounds: TRACK, paddle_y=0, ball_y=0 -> up=0; paddle_y=124, ball_y=127 -> down=0.
  - Flip/disable:
    - ball_x reverses mid-WAIT -> counter reloads, 2 more WAIT cycles.
    - enable=0 in TRACK -> state=0 and up=0, down=0 after one edge.
    - REACT_DELAY=0 -> SAMPLE goes straight to 3.

Source files
------------

// File: rtl/pong_ai_paddle.sv
// Pong AI paddle controller: watches ball motion, waits a short reaction time after each
// direction change, then chases the ball row (approaching) or drifts back to HOME_Y (receding).
module pong_ai_paddle #(
  parameter bit SIDE        = 1'b0,
  parameter int PADDLE_H    = 4,
  parameter int FIELD_MAX   = 127,
  parameter int HOME_Y      = 62,
  parameter int REACT_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [6:0] paddle_y,
  output logic       up,
  output logic       down,
  output logic [2:0] state
);

  // Handshake-free block: inputs are sampled every rising edge; up/down are registered
  // requests valid from the edge after the decision and hold until the next edge.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_TRACK  = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  localparam logic [7:0] RELOAD     = (REACT_DELAY == 0) ? 8'd0 : 8'(REACT_DELAY - 1);
  localparam logic [7:0] DOWN_LIMIT = 8'(FIELD_MAX - PADDLE_H + 1);
  localparam logic [7:0] HOME8      = 8'(HOME_Y);

  state_t     st;
  logic [6:0] prev_x;
  logic       dir;
  logic [7:0] counter;

  logic [7:0] by8, py8, bottom8;
  logic       moved, approach, flip;
  logic       up_req, dn_req, up_nxt, dn_nxt;
  state_t     entry_st;

  assign state    = st;
  assign by8      = {1'b0, ball_y};
  assign py8      = {1'b0, paddle_y};
  assign bottom8  = py8 + 8'(PADDLE_H - 1);
  assign moved    = (ball_x != prev_x);
  assign approach = SIDE ? (ball_x > prev_x) : (ball_x < prev_x);
  assign flip     = moved && (approach != dir);

  // On a new heading (first movement or a reversal) the new dir always equals approach.
  always_comb begin
    entry_st = ST_WAIT;
    if (REACT_DELAY == 0) entry_st = approach ? ST_TRACK : ST_RETURN;
  end

  always_comb begin
    up_req = 1'b0;
    dn_req = 1'b0;
    if (enable) begin
      case (st)
        ST_TRACK: begin
          up_req = (by8 < py8);
          dn_req = (by8 > bottom8);
        end
        ST_RETURN: begin
          up_req = (py8 > HOME8);
          dn_req = (py8 < HOME8);
        end
        default: ;
      endcase
    end
    up_nxt = up_req && (py8 != 8'd0);
    dn_nxt = dn_req && (py8 < DOWN_LIMIT) && !up_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_IDLE;
      up      <= 1'b0;
      down    <= 1'b0;
      prev_x  <= 7'd0;
      dir     <= 1'b0;
      counter <= 8'd0;
    end else begin
      up   <= up_nxt;
      down <= dn_nxt;
      if (!enable) begin
        st <= ST_IDLE;
      end else begin
        case (st)
          ST_IDLE: begin
            prev_x <= ball_x;
            st     <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            if (moved) begin
              prev_x  <= ball_x;
              dir     <= approach;
              counter <= RELOAD;
              st      <= entry_st;
            end
          end
          ST_WAIT, ST_TRACK, ST_RETURN: begin
            prev_x <= ball_x;
            if (flip) begin
              dir     <= approach;
              counter <= RELOAD;
              st      <= entry_st;
            end else if (st == ST_WAIT) begin
              if (counter == 8'd0) st <= dir ? ST_TRACK : ST_RETURN;
              else                 counter <= counter - 8'd1;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_ai_paddle.sv
// Directed bench for pong_ai_paddle: two instances (reaction delay 2 and 0) share stimulus and
// are checked every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_pong_ai_paddle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] ball_x, ball_y, paddle_y;
  logic       up_a, down_a, up_b, down_b;
  logic [2:0] state_a, state_b;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  pong_ai_paddle dut_a (
    .clk(clk), .reset(rst_n), .enable(enable),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .up(up_a), .down(down_a), .state(state_a)
  );

  pong_ai_paddle #(.REACT_DELAY(0)) dut_b (
    .clk(clk), .reset(rst_n), .enable(enable),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .up(up_b), .down(down_b), .state(state_b)
  );

  // Model phases: 0 idle, 1 sample, 2 wait, 3 track, 4 return.
  typedef struct packed {
    logic [2:0] st;
    logic [6:0] prev;
    logic       dir;
    logic [7:0] cnt;
    logic       up;
    logic       dn;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t react(mstate_t n, int d, bit newdir);
    mstate_t r = n;
    r.dir = newdir;
    if (d == 0) r.st = newdir ? 3'd3 : 3'd4;
    else begin
      r.st  = 3'd2;
      r.cnt = 8'(d - 1);
    end
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t s, int d, bit en,
                                         logic [6:0] bx, logic [6:0] by, logic [6:0] py);
    mstate_t n = s;
    int top = int'(py);
    int bot = int'(py) + 4 - 1;
    int row = int'(by);
    bit moved = (bx != s.prev);
    bit appr  = (bx < s.prev);
    n.up = 1'b0;
    n.dn = 1'b0;
    if (en && s.st == 3'd3) begin
      n.up = (row < top) && (top != 0);
      n.dn = (row > bot) && (top < 124);
    end else if (en && s.st == 3'd4) begin
      n.up = (top > 62);
      n.dn = (top < 62);
    end
    if (!en) begin
      n.st = 3'd0;
      return n;
    end
    case (s.st)
      3'd0: begin
        n.prev = bx;
        n.st   = 3'd1;
      end
      3'd1: if (moved) begin
        n.prev = bx;
        n = react(n, d, appr);
      end
      3'd2, 3'd3, 3'd4: begin
        n.prev = bx;
        if (moved && appr != s.dir) n = react(n, d, appr);
        else if (s.st == 3'd2) begin
          if (s.cnt == 8'd0) n.st = s.dir ? 3'd3 : 3'd4;
          else               n.cnt = s.cnt - 8'd1;
        end
      end
      default: n.st = 3'd0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= model_next(m[0], 2, enable, ball_x, ball_y, paddle_y);
      m[1] <= model_next(m[1], 0, enable, ball_x, ball_y, paddle_y);
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp("a_state", int'(state_a), int'(m[0].st));
      cmp("a_up",    int'(up_a),    int'(m[0].up));
      cmp("a_down",  int'(down_a),  int'(m[0].dn));
      cmp("b_state", int'(state_b), int'(m[1].st));
      cmp("b_up",    int'(up_b),    int'(m[1].up));
      cmp("b_down",  int'(down_b),  int'(m[1].dn));
      cmp("a_excl",  int'(up_a && down_a), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    ball_x   = 7'd0;
    ball_y   = 7'd0;
    paddle_y = 7'd0;
    #1 cmp_on = 1'b1;
    cmp("lit_reset_state", int'(state_a), 0);
    cmp("lit_reset_up",    int'(up_a),    0);
    cmp("lit_reset_down",  int'(down_a),  0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cmp("lit_disabled_idle", int'(state_a), 0);

    // Approach: ball_x 100 then 99
    enable = 1'b1; ball_x = 7'd100; ball_y = 7'd10; paddle_y = 7'd50;
    tick(1);
    cmp("lit_appr_sample_a", int'(state_a), 1);
    cmp("lit_appr_sample_b", int'(state_b), 1);
    ball_x = 7'd99;
    tick(1);
    cmp("lit_appr_wait1", int'(state_a), 2);
    cmp("lit_nodelay_track", int'(state_b), 3);
    tick(1);
    cmp("lit_appr_wait2", int'(state_a), 2);
    tick(1);
    cmp("lit_appr_track", int'(state_a), 3);
    cmp("lit_appr_up0",   int'(up_a), 0);
    tick(1);
    cmp("lit_appr_up1",   int'(up_a), 1);
    cmp("lit_appr_down0", int'(down_a), 0);

    // Window
    ball_y = 7'd52;
    tick(1);
    cmp("lit_window_up",   int'(up_a), 0);
    cmp("lit_window_down", int'(down_a), 0);
    ball_y = 7'd54;
    tick(1);
    cmp("lit_below_down", int'(down_a), 1);

    // Bounds
    paddle_y = 7'd0; ball_y = 7'd0;
    tick(1);
    cmp("lit_top_up", int'(up_a), 0);
    paddle_y = 7'd124; ball_y = 7'd127;
    tick(1);
    cmp("lit_bottom_down", int'(down_a), 0);
    paddle_y = 7'd123;
    tick(1);
    cmp("lit_near_bottom_down", int'(down_a), 1);

    // Reversal mid-WAIT reloads the counter
    paddle_y = 7'd50; ball_y = 7'd10; ball_x = 7'd100;
    tick(1);
    cmp("lit_flip_wait", int'(state_a), 2);
    cmp("lit_flip_b_return", int'(state_b), 4);
    ball_x = 7'd99;
    tick(1);
    cmp("lit_reflip_wait1", int'(state_a), 2);
    tick(1);
    cmp("lit_reflip_wait2", int'(state_a), 2);
    tick(1);
    cmp("lit_reflip_track", int'(state_a), 3);
    tick(1);
    cmp("lit_track_up", int'(up_a), 1);

    // Disable in TRACK
    enable = 1'b0;
    tick(1);
    cmp("lit_dis_state", int'(state_a), 0);
    cmp("lit_dis_up",    int'(up_a), 0);
    cmp("lit_dis_down",  int'(down_a), 0);

    // Recede and return home
    enable = 1'b1; ball_x = 7'd40; paddle_y = 7'd20;
    tick(1);
    ball_x = 7'd41;
    tick(3);
    cmp("lit_recede_return", int'(state_a), 4);
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (!down_a && paddle_y == 7'd62) break;
      if (down_a) paddle_y = paddle_y + 7'd1;
    end
    cmp("lit_home_reached", int'(paddle_y), 62);
    cmp("lit_home_up",   int'(up_a), 0);
    cmp("lit_home_down", int'(down_a), 0);
    paddle_y = 7'd70;
    tick(1);
    cmp("lit_above_home_up", int'(up_a), 1);

    // Reset mid-TRACK
    paddle_y = 7'd50; ball_x = 7'd40;
    tick(4);
    cmp("lit_pre_reset_up", int'(up_a), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("lit_async_state", int'(state_a), 0);
    cmp("lit_async_up",    int'(up_a), 0);
    cmp("lit_async_down",  int'(down_a), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    cmp("lit_restart_sample", int'(state_a), 1);
    tick(1);
    cmp("lit_restart_hold", int'(state_a), 1);
    tick(2);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
